// File: rtl/vga_layer_arbiter_if.sv
// Video-side bundle between the VGA timing source and the layer arbiter.
// The master drives timing and layer pixels; the slave returns the composite.
interface vga_layer_arbiter_if #(
   parameter int COLOR_W = 24
);
   logic                   DISP_EN;
   logic                   VGA_VS;
   logic [3:0]             LAYER_REQ;
   logic [4*COLOR_W-1:0]   LAYER_RGB;
   logic [COLOR_W-1:0]     RGB;
   logic [3:0]             GRANT;

   modport master (
      output DISP_EN,
      output VGA_VS,
      output LAYER_REQ,
      output LAYER_RGB,
      input  RGB,
      input  GRANT
   );

   modport slave (
      input  DISP_EN,
      input  VGA_VS,
      input  LAYER_REQ,
      input  LAYER_RGB,
      output RGB,
      output GRANT
   );
endinterface

// File: rtl/vga_layer_arbiter.sv
// Four-layer priority compositor with frame-synchronous config and blinking.
// Layer 3 wins; config writes take effect on the next VS falling edge.
module vga_layer_arbiter #(
   parameter int COLOR_W      = 24,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                VGA_CLK,
   input  logic                RESET,
   vga_layer_arbiter_if.slave  vid,
   input  logic                CFG_WE,
   input  logic [3:0]          CFG_EN,
   input  logic [3:0]          CFG_BLINK,
   input  logic [COLOR_W-1:0]  CFG_BG,
   output logic                CFG_PENDING,
   output logic [7:0]          FRAME_CNT
);

   localparam logic [0:0] ST_WAIT_VS = 1'b0;
   localparam logic [0:0] ST_RUN     = 1'b1;
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic [0:0]          r_state;
   logic                r_vs_d;
   logic                r_pending;
   logic [7:0]          r_frame_cnt;
   logic [7:0]          r_blink_cnt;
   logic                r_phase;
   logic [3:0]          r_sh_en;
   logic [3:0]          r_sh_blink;
   logic [COLOR_W-1:0]  r_sh_bg;
   logic [3:0]          r_act_en;
   logic [3:0]          r_act_blink;
   logic [COLOR_W-1:0]  r_act_bg;
   logic [COLOR_W-1:0]  r_rgb;
   logic [3:0]          r_grant;

   logic                w_edge;
   logic [3:0]          w_elig;
   logic [3:0]          w_grant;
   logic [COLOR_W-1:0]  w_pix;

   assign w_edge = r_vs_d & ~vid.VGA_VS;
   assign w_elig = r_act_en & vid.LAYER_REQ
                 & ~(r_act_blink & {4{r_phase}});

   always_comb begin
      w_grant = 4'b0000;
      w_pix   = r_act_bg;
      if (w_elig[3]) begin
         w_grant = 4'b1000;
         w_pix   = vid.LAYER_RGB[3*COLOR_W +: COLOR_W];
      end else if (w_elig[2]) begin
         w_grant = 4'b0100;
         w_pix   = vid.LAYER_RGB[2*COLOR_W +: COLOR_W];
      end else if (w_elig[1]) begin
         w_grant = 4'b0010;
         w_pix   = vid.LAYER_RGB[1*COLOR_W +: COLOR_W];
      end else if (w_elig[0]) begin
         w_grant = 4'b0001;
         w_pix   = vid.LAYER_RGB[0 +: COLOR_W];
      end
   end

   // A write coinciding with the edge bypasses the shadow delay entirely.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET) begin
         r_vs_d      <= 1'b0;
         r_pending   <= 1'b0;
         r_sh_en     <= '0;
         r_sh_blink  <= '0;
         r_sh_bg     <= '0;
         r_act_en    <= '0;
         r_act_blink <= '0;
         r_act_bg    <= '0;
      end else begin
         r_vs_d <= vid.VGA_VS;
         if (CFG_WE) begin
            r_sh_en    <= CFG_EN;
            r_sh_blink <= CFG_BLINK;
            r_sh_bg    <= CFG_BG;
         end
         if (w_edge) begin
            r_pending <= 1'b0;
            if (CFG_WE) begin
               r_act_en    <= CFG_EN;
               r_act_blink <= CFG_BLINK;
               r_act_bg    <= CFG_BG;
            end else begin
               r_act_en    <= r_sh_en;
               r_act_blink <= r_sh_blink;
               r_act_bg    <= r_sh_bg;
            end
         end else if (CFG_WE) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (!RESET) begin
         r_state     <= ST_WAIT_VS;
         r_frame_cnt <= 8'd0;
         r_blink_cnt <= 8'd0;
         r_phase     <= 1'b0;
      end else if (r_state == ST_WAIT_VS) begin
         if (w_edge) begin
            r_state     <= ST_RUN;
            r_blink_cnt <= 8'd0;
            r_phase     <= 1'b0;
         end
      end else if (w_edge) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= 8'd0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (!RESET) begin
         r_rgb   <= '0;
         r_grant <= 4'b0000;
      end else if (r_state == ST_RUN && vid.DISP_EN) begin
         r_rgb   <= w_pix;
         r_grant <= w_grant;
      end else begin
         r_rgb   <= '0;
         r_grant <= 4'b0000;
      end
   end

   assign vid.RGB     = r_rgb;
   assign vid.GRANT   = r_grant;
   assign CFG_PENDING = r_pending;
   assign FRAME_CNT   = r_frame_cnt;

endmodule

// File: doc/vga_layer_arbiter.md
VGA_LAYER_ARBITER -- requirements
Module: vga_layer_arbiter

Interface
REQ-001 SHALL have parameter COLOR_W, default 24, meaning pixel colour width (8 bits each for R, G and B).
REQ-002 SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per blink phase (legal range 1-255).
REQ-003 SHALL have port VGA_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port DISP_EN, input, 1 bit: active-video flag from the VGA controller.
REQ-006 SHALL have port VGA_VS, input, 1 bit: vertical sync from the VGA controller (active low).
REQ-007 SHALL have port LAYER_REQ, input, 4 bits: per-layer "pixel opaque at current X,Y" request.
REQ-008 SHALL have port LAYER_RGB, input, 4*COLOR_W bits: layer i colour in bits [i*COLOR_W +: COLOR_W].
REQ-009 SHALL have port CFG_WE, input, 1 bit: one-cycle configuration write strobe.
REQ-010 SHALL have port CFG_EN, input, 4 bits: layer enable mask to write.
REQ-011 SHALL have port CFG_BLINK, input, 4 bits: layer blink mask to write.
REQ-012 SHALL have port CFG_BG, input, COLOR_W bits: background colour to write.
REQ-013 SHALL have port RGB, output, COLOR_W bits: registered composite pixel, feeding the VGA controller RGB input.
REQ-014 SHALL have port GRANT, output, 4 bits: registered one-hot winning layer, or zero.
REQ-015 SHALL have port CFG_PENDING, output, 1 bit: a shadow configuration is waiting for the next frame.
REQ-016 SHALL have port FRAME_CNT, output, 8 bits: completed-frame counter.

Function
REQ-017 SHALL detect a frame edge as VGA_VS registered value 1 and current value 0 (falling edge), with the edge register reset to 0.
REQ-018 SHALL implement FSM WAIT_VS -> RUN; WAIT_VS SHALL hold RGB=0, GRANT=0 and FRAME_CNT frozen, and SHALL move to RUN on the first frame edge.
REQ-019 SHALL, in RUN, never leave RUN except by reset.
REQ-020 SHALL keep shadow registers (EN, BLINK, BG) written on CFG_WE; CFG_WE SHALL set CFG_PENDING to 1, and a second write before the edge SHALL overwrite the shadow.
REQ-021 SHALL copy shadow to active configuration on every frame edge and clear CFG_PENDING.
REQ-022 SHALL, when CFG_WE coincides with a frame edge, load the written values directly into shadow and active configuration and leave CFG_PENDING 0.
REQ-023 SHALL mark layer i eligible when active EN[i]=1 and LAYER_REQ[i]=1, and not (active BLINK[i]=1 and blink phase=1).
REQ-024 SHALL grant the highest-index eligible layer (layer 3 has the highest priority).
REQ-025 SHALL register RGB and GRANT with latency exactly 1 cycle from DISP_EN, LAYER_REQ and LAYER_RGB.
REQ-026 SHALL output the granted layer colour; with no eligible layer it SHALL output active BG with GRANT=0; with DISP_EN=0 it SHALL output RGB=0 with GRANT=0.
REQ-027 SHALL, in RUN, increment FRAME_CNT on each frame edge, wrapping 255 -> 0.
REQ-028 SHALL keep an 8-bit blink counter counting frame edges in RUN; on reaching BLINK_FRAMES-1 it SHALL return to 0 and toggle the blink phase.
REQ-029 SHALL take on the frame edge that causes the WAIT_VS -> RUN transition: the configuration load and blink-counter setup; it SHALL NOT increment FRAME_CNT on that edge.

Reset
REQ-030 SHALL, with RESET=0 at a clock edge, force: state WAIT_VS, RGB=0, GRANT=0, CFG_PENDING=0, FRAME_CNT=0, blink counter 0, blink phase 0, shadow and active EN=0, BLINK=0, BG=0.
REQ-031 SHALL apply reset identically mid-frame or mid-pending; a pending configuration SHALL be discarded.

Verification
REQ-032 Reset then no VS edge, DISP_EN=1, LAYER_REQ=4'hF -> RGB=0, GRANT=0 for all cycles.
REQ-033 CFG_WE with EN=4'b0101, BG=24'h102030, then VS fall, then DISP_EN=1 with LAYER_REQ=4'b0111 -> CFG_PENDING 1 until the edge, then 0; GRANT=4'b0100 and RGB=LAYER_RGB[2] one cycle later; LAYER_REQ=0 -> RGB=24'h102030.
REQ-034 DISP_EN dropped to 0 mid-line -> RGB=0 and GRANT=0 exactly one cycle later.
REQ-035 CFG_WE asserted on the exact VS-fall cycle with EN=4'b1000 -> new EN active from the next cycle; CFG_PENDING stays 0.
REQ-036 BLINK_FRAMES=2, BLINK=4'b0001, only layer 0 requesting, 6 frames -> layer 0 shown 2 frames, BG 2 frames, shown 2 frames; FRAME_CNT wraps 255 -> 0 after 256 edges.
REQ-037 Reset asserted while CFG_PENDING=1 -> pending cleared and old shadow not applied at the next edge.
